// File: rtl/rv32i_pipe_pkg.sv
// rv32i_pipe_pkg
// Shared types for the decode-to-execute pipeline register.
//   id_ex_payload_t : one decoded instruction (payload + control bits)
//   NOP_INSTR_C     : addi x0,x0,0, the instruction word carried by a bubble
//   bubble_payload(): bubble value; every control bit 0, so no register
//                     write or memory access can come out of a bubble
// Field widths are the maximum supported by id_ex_pipe_reg; narrower
// parameterisations zero-extend into these fields.
package rv32i_pipe_pkg;

    localparam int PIPE_XLEN  = 32;
    localparam int PIPE_ILEN  = 32;
    localparam int PIPE_ALU_W = 4;

    localparam logic [PIPE_ILEN-1:0] NOP_INSTR_C = 32'h0000_0013;

    typedef struct packed {
        logic [PIPE_ILEN-1:0]  instruction;
        logic [PIPE_XLEN-1:0]  pc;
        logic [PIPE_ALU_W-1:0] alu_control;
        logic [PIPE_XLEN-1:0]  opa;
        logic [PIPE_XLEN-1:0]  opb;
        logic                  load;
        logic                  store;
        logic                  branch;
        logic                  next_sel;
        logic                  jalr;
        logic                  branch_result;
        logic                  mem_en;
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
    } id_ex_payload_t;

    function automatic id_ex_payload_t bubble_payload(
        input logic [PIPE_ILEN-1:0] nop = NOP_INSTR_C
    );
        id_ex_payload_t p;
        p             = '0;
        p.instruction = nop;
        return p;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Saturating up-counter for pipeline performance statistics.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value; sticks at all-ones instead of wrapping
module pipe_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
// Decode-to-execute pipeline register with valid/ready handshake,
// flush with NOP-bubble insertion and saturating perf counters.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : decode-side handshake
//   out_valid / out_ready    : execute-side handshake
//   flush                    : drop held and incoming instruction
//   instruction .. mem_to_reg: decode payload and control bits
//   *_decode_pp              : registered payload toward execute
//   stall_cnt                : cycles with out_valid & ~out_ready
//   bubble_cnt               : cycles with out_valid == 0
//   flush_cnt                : cycles with flush asserted
// DATA_WIDTH / INSTRUCTION / ALU_CONTROL may not exceed the package widths.
module id_ex_pipe_reg
    import rv32i_pipe_pkg::*;
#(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     INSTRUCTION = 32,
    parameter int                     ALU_CONTROL = 4,
    parameter int                     CNT_WIDTH   = 32,
    parameter logic [INSTRUCTION-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic [INSTRUCTION-1:0] instruction,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [ALU_CONTROL-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0]  opa_mux_out,
    input  logic [DATA_WIDTH-1:0]  opb_mux_out,
    input  logic                   Load,
    input  logic                   Store,
    input  logic                   Branch,
    input  logic                   next_sel,
    input  logic                   Jalr,
    input  logic                   branch_result,
    input  logic                   mem_en,
    input  logic                   reg_write,
    input  logic [1:0]             mem_to_reg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTRUCTION-1:0] instruction_decode_pp,
    output logic [DATA_WIDTH-1:0]  pc_decode_pp,
    output logic [ALU_CONTROL-1:0] alu_control_decode_pp,
    output logic [DATA_WIDTH-1:0]  opa_mux_out_decode_pp,
    output logic [DATA_WIDTH-1:0]  opb_mux_out_decode_pp,
    output logic                   Load_decode_pp,
    output logic                   Store_decode_pp,
    output logic                   Branch_decode_pp,
    output logic                   next_sel_decode_pp,
    output logic                   Jalr_decode_pp,
    output logic                   branch_result_decode_pp,
    output logic                   mem_en_decode_pp,
    output logic                   reg_write_decode_pp,
    output logic [1:0]             mem_to_reg_decode_pp,
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    output logic [CNT_WIDTH-1:0]   bubble_cnt,
    output logic [CNT_WIDTH-1:0]   flush_cnt
);

    id_ex_payload_t pl_in;
    id_ex_payload_t pl_q;
    id_ex_payload_t pl_bubble;
    logic           valid_q;

    assign pl_bubble = bubble_payload(PIPE_ILEN'(NOP_INSTR));

    always_comb begin
        pl_in               = '0;
        pl_in.instruction   = PIPE_ILEN'(instruction);
        pl_in.pc            = PIPE_XLEN'(pc);
        pl_in.alu_control   = PIPE_ALU_W'(alu_control);
        pl_in.opa           = PIPE_XLEN'(opa_mux_out);
        pl_in.opb           = PIPE_XLEN'(opb_mux_out);
        pl_in.load          = Load;
        pl_in.store         = Store;
        pl_in.branch        = Branch;
        pl_in.next_sel      = next_sel;
        pl_in.jalr          = Jalr;
        pl_in.branch_result = branch_result;
        pl_in.mem_en        = mem_en;
        pl_in.reg_write     = reg_write;
        pl_in.mem_to_reg    = mem_to_reg;
    end

    // Depends only on registered state and out_ready, never on in_valid/flush.
    assign in_ready = ~valid_q | out_ready;

    // Flush outranks accept: an instruction handed over during flush is
    // considered consumed by upstream but never reaches execute.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            pl_q    <= pl_bubble;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            pl_q    <= pl_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
            pl_q    <= pl_bubble;
        end
    end

    assign out_valid             = valid_q;
    assign instruction_decode_pp = pl_q.instruction[INSTRUCTION-1:0];
    assign pc_decode_pp          = pl_q.pc[DATA_WIDTH-1:0];
    assign alu_control_decode_pp = pl_q.alu_control[ALU_CONTROL-1:0];
    assign opa_mux_out_decode_pp = pl_q.opa[DATA_WIDTH-1:0];
    assign opb_mux_out_decode_pp = pl_q.opb[DATA_WIDTH-1:0];

    // Second line of defence: side-effecting controls are gated by valid so
    // a bubble can never issue a write even if the payload were stale.
    assign Load_decode_pp          = pl_q.load          & valid_q;
    assign Store_decode_pp         = pl_q.store         & valid_q;
    assign Branch_decode_pp        = pl_q.branch        & valid_q;
    assign next_sel_decode_pp      = pl_q.next_sel      & valid_q;
    assign Jalr_decode_pp          = pl_q.jalr          & valid_q;
    assign branch_result_decode_pp = pl_q.branch_result & valid_q;
    assign mem_en_decode_pp        = pl_q.mem_en        & valid_q;
    assign reg_write_decode_pp     = pl_q.reg_write     & valid_q;
    assign mem_to_reg_decode_pp    = pl_q.mem_to_reg    & {2{valid_q}};

    pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid_q & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~valid_q),
        .count (bubble_cnt)
    );

    pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
